mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the core's data-memory port.
- Accepts one load or store request at a time over a valid/ready request channel.
- Accesses an internal doubleword-wide backing array after a configurable latency.
- Returns read data over a valid/ready response channel.
- Lets the core move from a combinational memory model to a multi-cycle, handshaked memory.

Parameters:
- ADDR_WIDTH, 64, request address width.
- DATA_WIDTH, 64, data width; 8 byte lanes.
- DEPTH, 4096, number of DATA_WIDTH words in the array; power of two.
- BASE_ADDR, 64'h8000_0000, byte address of word 0.
- LATENCY, 2, cycles from request acceptance to resp_valid; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset; asynchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_addr  input  ADDR_WIDTH  byte address.
- req_wen  input  1  1 = store, 0 = load.
- req_wdata  input  DATA_WIDTH  store data, lane-aligned.
- req_wmask  input  8  store byte-lane enables.
- resp_valid  output  1  response present.
- resp_ready  input  1  core accepts the response.
- resp_rdata  output  DATA_WIDTH  aligned doubleword for loads; 0 for stores.
- resp_err  output  1  access error; tied 0 unless MEM_RESP_ERR_EN is defined.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE, resp_valid = 0, resp_rdata = 0, resp_err = 0, latency counter = 0.
  - req_ready = 1 once reset releases.
  - Array contents are not reset.
- States: IDLE, WAIT, RESP.
- req_ready = (state == IDLE), combinational. resp_valid = (state == RESP), registered.
- IDLE:
  - On req_valid & req_ready, capture addr, wen, wdata and wmask.
  - If LATENCY == 1, go to RESP. Otherwise load cnt = LATENCY-2 and go to WAIT.
- WAIT:
  - If cnt != 0, decrement cnt.
  - If cnt == 0, go to RESP.
- The access is performed on the edge that enters RESP:
  - Load: resp_rdata <= array[idx].
  - Store: array[idx] byte lane b <= wdata lane b for each wmask[b] = 1; resp_rdata <= 0.
  - wmask = 0 makes a store a no-op that still produces a response.
- Index: idx = ((addr - BASE_ADDR) >> 3)[log2(DEPTH)-1:0]. addr[2:0] is ignored; the core performs byte/half/word extraction and sign-extension.
- Latency: resp_valid rises exactly LATENCY cycles after the accept edge.
- RESP:
  - resp_rdata and resp_err are held stable while resp_valid = 1 and resp_ready = 0. There is no timeout.
  - On resp_ready, go to IDLE.
- Only one request is outstanding at a time. A request offered during RESP is accepted the cycle after the response handshake, giving one bubble.
- Reset mid-operation aborts the transaction:
  - If rst asserts before the commit edge, the store is discarded.
  - If rst asserts after the commit edge, the store persists.
- The request capture registers update only on acceptance. req_* inputs are don't-care outside IDLE.

Optional Feature:
- Macro: MEM_RESP_ERR_EN.
- Defined:
  - Address range check: addr < BASE_ADDR or addr >= BASE_ADDR + DEPTH*8 gives resp_err = 1 with the response.
  - On error, the store is suppressed and resp_rdata = 0.
  - Latency and handshake are unchanged.
- Undefined:
  - No range check; the index wraps modulo DEPTH.
  - resp_err is a constant 0.

Decomposition:
- Package mem_resp_pkg:
  - state enum (IDLE, WAIT, RESP).
  - BYTE_LANES = DATA_WIDTH/8.
  - Counter width constant (4 bits).
- Sub-module mem_resp_array:
  - Single-port synchronous array, DEPTH x DATA_WIDTH.
  - Ports: en, wen, 8-bit byte-lane write mask, idx, wdata, rdata.
  - The FSM drives en on the commit edge only.

Test Plan:
- Reset with rst = 0 mid-WAIT, then release -> resp_valid = 0, req_ready = 1, no response emitted.
- Store addr 0x8000_0010, wdata 0x1122334455667788, wmask 0xFF; then load same address -> resp_rdata = 0x1122334455667788, resp_valid exactly 2 cycles after each accept.
- Store addr 0x8000_0010, wdata 0xAAAA..AA, wmask 0x0F; load -> resp_rdata = 0x11223344AAAAAAAA.
- Load with resp_ready held 0 for 5 cycles -> resp_valid and resp_rdata stable; req_ready = 0 throughout; next request accepted the cycle after the handshake.
- LATENCY = 1 build, back-to-back loads with resp_ready = 1 -> one response every 2 cycles, resp_valid one cycle after each accept.
- MEM_RESP_ERR_EN defined, store to 0x7FFF_FFF8 then load of word 0 -> resp_err = 1 on the store, word 0 unchanged; undefined -> store wraps into word DEPTH-1 per the index rule, resp_err = 0.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the mem_responder slice.
package mem_resp_pkg;

    localparam int unsigned DATA_WIDTH_DFLT = 64;
    localparam int unsigned BYTE_LANES      = DATA_WIDTH_DFLT / 8;
    localparam int unsigned CNT_W           = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/mem_resp_array.sv
// Single-port synchronous doubleword array with byte-lane write enables.
module mem_resp_array
    import mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH      = 4096,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     wen,
    input  logic [BYTE_LANES-1:0]    wmask,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [DATA_WIDTH-1:0]    wdata,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Contents and read register are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (wen) begin
                for (int unsigned b = 0; b < BYTE_LANES; b++) begin
                    if (wmask[b]) r_mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end else begin
                rdata <= r_mem[idx];
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Handshaked data-memory responder with fixed access latency.
// Optional address range check enabled by defining MEM_RESP_ERR_EN.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 4096,
    parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_wen,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [BYTE_LANES-1:0] req_wmask,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err
);

    localparam int unsigned          IDX_W    = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] BASE    = BASE_ADDR[ADDR_WIDTH-1:0];
    localparam logic [CNT_W-1:0]      CNT_INIT = CNT_W'((LATENCY >= 2) ? LATENCY - 2 : 0);

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_wen;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [BYTE_LANES-1:0] r_wmask;
    logic                  r_resp_valid;
    logic                  r_load_resp;

    logic                  w_commit;
    logic                  w_ok;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_wen;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [BYTE_LANES-1:0] w_wmask;
    logic [IDX_W-1:0]      w_idx;
    logic [DATA_WIDTH-1:0] w_rdata;

    // With LATENCY == 1 the commit edge is the accept edge, so the array
    // must see the live request rather than the capture registers.
    assign w_addr  = (r_state == IDLE) ? req_addr  : r_addr;
    assign w_wen   = (r_state == IDLE) ? req_wen   : r_wen;
    assign w_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
    assign w_wmask = (r_state == IDLE) ? req_wmask : r_wmask;
    assign w_idx   = IDX_W'((w_addr - BASE) >> 3);

    assign w_commit = ((r_state == IDLE) && req_valid && (LATENCY == 1))
                   || ((r_state == WAIT) && (r_cnt == '0));

`ifdef MEM_RESP_ERR_EN
    localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(64'(DEPTH) * 64'd8);
    logic r_err;

    assign w_ok = (w_addr >= BASE) && ((w_addr - BASE) < SPAN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          r_err <= 1'b0;
        else if (w_commit) r_err <= !w_ok;
    end

    assign resp_err = r_err;
`else
    assign w_ok     = 1'b1;
    assign resp_err = 1'b0;
`endif

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_load_resp ? w_rdata : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_wen        <= 1'b0;
            r_wdata      <= '0;
            r_wmask      <= '0;
            r_resp_valid <= 1'b0;
            r_load_resp  <= 1'b0;
        end else begin
            if (w_commit) r_load_resp <= !w_wen && w_ok;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_addr  <= req_addr;
                        r_wen   <= req_wen;
                        r_wdata <= req_wdata;
                        r_wmask <= req_wmask;
                        if (LATENCY == 1) begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                        end else begin
                            r_cnt   <= CNT_INIT;
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        r_state      <= IDLE;
                        r_resp_valid <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    mem_resp_array #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clk   (clk),
        .en    (w_commit && w_ok),
        .wen   (w_wen),
        .wmask (w_wmask),
        .idx   (w_idx),
        .wdata (w_wdata),
        .rdata (w_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: default instance plus a LATENCY=1 instance.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_wen = 1'b0, resp_ready = 1'b0;
    logic [63:0] req_addr = '0, req_wdata = '0;
    logic [7:0]  req_wmask = '0;
    logic        req_ready, resp_valid, resp_err;
    logic [63:0] resp_rdata;

    logic        req_valid2 = 1'b0, req_wen2 = 1'b0, resp_ready2 = 1'b0;
    logic [63:0] req_addr2 = '0, req_wdata2 = '0;
    logic [7:0]  req_wmask2 = '0;
    logic        req_ready2, resp_valid2, resp_err2;
    logic [63:0] resp_rdata2;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] VAL_A = 64'hA5A5_0000_1234_5678;
    localparam logic [63:0] VAL_B = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] VAL_C = 64'hC0C0_C0C0_0BAD_F00D;
    localparam logic [63:0] VAL_D = 64'h0123_4567_89AB_CDEF;

    always #5 clk = ~clk;

    mem_responder #(
        .ADDR_WIDTH (64), .DATA_WIDTH (64), .DEPTH (4096),
        .BASE_ADDR  (64'h8000_0000), .LATENCY (2)
    ) dut (
        .clk (clk), .rst (rst),
        .req_valid (req_valid), .req_ready (req_ready), .req_addr (req_addr),
        .req_wen (req_wen), .req_wdata (req_wdata), .req_wmask (req_wmask),
        .resp_valid (resp_valid), .resp_ready (resp_ready),
        .resp_rdata (resp_rdata), .resp_err (resp_err)
    );

    mem_responder #(
        .ADDR_WIDTH (64), .DATA_WIDTH (64), .DEPTH (16),
        .BASE_ADDR  (64'h8000_0000), .LATENCY (1)
    ) dut_l1 (
        .clk (clk), .rst (rst),
        .req_valid (req_valid2), .req_ready (req_ready2), .req_addr (req_addr2),
        .req_wen (req_wen2), .req_wdata (req_wdata2), .req_wmask (req_wmask2),
        .resp_valid (resp_valid2), .resp_ready (resp_ready2),
        .resp_rdata (resp_rdata2), .resp_err (resp_err2)
    );

    // Issue one request on the default instance; returns at the first negedge
    // with resp_valid high (lat counts edges from the accept edge inclusive).
    task automatic do_req(input logic wen, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [7:0] wmask,
                          output int lat, output logic [63:0] rd, output logic er);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_wen = wen; req_addr = addr;
        req_wdata = wdata; req_wmask = wmask; resp_ready = 1'b0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin @(negedge clk); lat++; end
        rd = resp_rdata;
        er = resp_err;
    endtask

    task automatic handshake;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", resp_valid); end
        checks++; if (resp_rdata !== 64'd0) begin errors++; $display("FAIL rst_rdata got %h exp 0", resp_rdata); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", resp_err); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", req_ready); end
        checks++; if (req_ready2 !== 1'b1) begin errors++; $display("FAIL rst_ready2 got %b exp 1", req_ready2); end
    endtask

    task automatic test_store_load;
        int lat; logic [63:0] rd; logic er;
        do_req(1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, lat, rd, er);
        checks++; if (lat !== 2) begin errors++; $display("FAIL st_lat got %0d exp 2", lat); end
        checks++; if (rd !== 64'd0) begin errors++; $display("FAIL st_rdata got %h exp 0", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL st_err got %b exp 0", er); end
        handshake();
        do_req(1'b0, 64'h8000_0010, 64'd0, 8'h00, lat, rd, er);
        checks++; if (lat !== 2) begin errors++; $display("FAIL ld_lat got %0d exp 2", lat); end
        checks++; if (rd !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL ld_rdata got %h exp 1122334455667788", rd); end
        handshake();
    endtask

    task automatic test_partial;
        int lat; logic [63:0] rd; logic er;
        do_req(1'b1, 64'h8000_0010, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, lat, rd, er);
        handshake();
        do_req(1'b1, 64'h8000_0014, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, lat, rd, er);
        checks++; if (lat !== 2) begin errors++; $display("FAIL noop_lat got %0d exp 2", lat); end
        handshake();
        do_req(1'b0, 64'h8000_0017, 64'd0, 8'h00, lat, rd, er);
        checks++; if (rd !== 64'h1122_3344_AAAA_AAAA) begin errors++; $display("FAIL part_rdata got %h exp 11223344aaaaaaaa", rd); end
        handshake();
    endtask

    task automatic test_abort;
        int lat; logic [63:0] rd; logic er;
        int seen = 0;
        do_req(1'b1, 64'h8000_0020, VAL_A, 8'hFF, lat, rd, er);
        handshake();
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b1; req_addr = 64'h8000_0020;
        req_wdata = VAL_B; req_wmask = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b exp 0", resp_valid); end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_noresp got %0d exp 0", seen); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b exp 1", req_ready); end
        do_req(1'b0, 64'h8000_0020, 64'd0, 8'h00, lat, rd, er);
        checks++; if (rd !== VAL_A) begin errors++; $display("FAIL abort_data got %h exp %h", rd, VAL_A); end
        handshake();
    endtask

    task automatic test_backpressure;
        int lat; logic [63:0] rd; logic er;
        int bad = 0;
        do_req(1'b0, 64'h8000_0010, 64'd0, 8'h00, lat, rd, er);
        checks++; if (rd !== 64'h1122_3344_AAAA_AAAA) begin errors++; $display("FAIL bp_rdata got %h exp 11223344aaaaaaaa", rd); end
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 64'h8000_0020;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b1 || resp_rdata !== 64'h1122_3344_AAAA_AAAA || req_ready !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold got %0d bad cycles exp 0", bad); end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL bp_bubble got ready %b valid %b exp 1 0", req_ready, resp_valid);
        end
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_accept got ready %b exp 0", req_ready); end
        lat = 1;
        while (!resp_valid && lat < 20) begin @(negedge clk); lat++; end
        checks++; if (lat !== 2) begin errors++; $display("FAIL bp_lat got %0d exp 2", lat); end
        checks++; if (resp_rdata !== VAL_A) begin errors++; $display("FAIL bp_next got %h exp %h", resp_rdata, VAL_A); end
        handshake();
    endtask

    task automatic test_range;
        int lat; logic [63:0] rd; logic er;
        do_req(1'b1, 64'h8000_0000, VAL_D, 8'hFF, lat, rd, er);
        handshake();
        do_req(1'b1, 64'h7FFF_FFF8, VAL_C, 8'hFF, lat, rd, er);
`ifdef MEM_RESP_ERR_EN
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL lo_err got %b exp 1", er); end
`else
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL lo_err got %b exp 0", er); end
`endif
        checks++; if (lat !== 2 || rd !== 64'd0) begin errors++; $display("FAIL lo_resp got lat %0d rdata %h exp 2 0", lat, rd); end
        handshake();
        do_req(1'b0, 64'h8000_0000, 64'd0, 8'h00, lat, rd, er);
        checks++; if (rd !== VAL_D || er !== 1'b0) begin errors++; $display("FAIL word0 got %h err %b exp %h 0", rd, er, VAL_D); end
        handshake();
        do_req(1'b0, 64'h8000_8000, 64'd0, 8'h00, lat, rd, er);
`ifdef MEM_RESP_ERR_EN
        checks++; if (rd !== 64'd0 || er !== 1'b1) begin errors++; $display("FAIL hi_load got %h err %b exp 0 1", rd, er); end
`else
        checks++; if (rd !== VAL_D || er !== 1'b0) begin errors++; $display("FAIL hi_wrap got %h err %b exp %h 0", rd, er, VAL_D); end
        handshake();
        do_req(1'b0, 64'h8000_7FF8, 64'd0, 8'h00, lat, rd, er);
        checks++; if (rd !== VAL_C) begin errors++; $display("FAIL lo_wrap got %h exp %h", rd, VAL_C); end
`endif
        handshake();
    endtask

    task automatic test_back_to_back;
        logic        t_wen  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [63:0] t_addr [4] = '{64'h8000_0000, 64'h8000_0008, 64'h8000_0000, 64'h8000_0008};
        logic [63:0] t_data [4] = '{VAL_B, VAL_C, 64'd0, 64'd0};
        logic [63:0] t_exp  [4] = '{64'd0, 64'd0, VAL_B, VAL_C};
        @(negedge clk);
        req_valid2 = 1'b1; resp_ready2 = 1'b1; req_wmask2 = 8'hFF;
        req_wen2 = t_wen[0]; req_addr2 = t_addr[0]; req_wdata2 = t_data[0];
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            checks++; if (req_ready2 !== 1'b1 || resp_valid2 !== 1'b0) begin
                errors++; $display("FAIL b2b_idle%0d got ready %b valid %b exp 1 0", i, req_ready2, resp_valid2);
            end
            @(negedge clk);
            checks++; if (resp_valid2 !== 1'b1 || req_ready2 !== 1'b0 || resp_rdata2 !== t_exp[i] || resp_err2 !== 1'b0) begin
                errors++; $display("FAIL b2b_resp%0d got valid %b rdata %h exp 1 %h", i, resp_valid2, resp_rdata2, t_exp[i]);
            end
            if (i < 3) begin
                req_wen2 = t_wen[i+1]; req_addr2 = t_addr[i+1]; req_wdata2 = t_data[i+1];
            end
        end
        req_valid2 = 1'b0;
        @(negedge clk);
        resp_ready2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_partial();
        test_abort();
        test_backpressure();
        test_range();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
